// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding, decode
// handshake constants, trap cause codes and the reset/trap vectors.
package sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    localparam logic [2:0]  CSTATE_IDLE   = 3'b111;
    localparam logic [2:0]  CSTATE_DONE   = 3'b011;
    localparam logic [3:0]  CAUSE_IFAULT  = 4'd1;
    localparam logic [3:0]  CAUSE_ILLEGAL = 4'd2;
    localparam logic [63:0] RESET_PC_DEF  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] TRAP_VEC_DEF  = 64'hFFFF_FFFF_FFFF_FE00;

endpackage

// File: rtl/sequencer.sv
// Instruction sequencer: fetches into IR, walks decode's cstate, advances PC.
// Optional trapping on bus error / undefined instruction: SEQUENCER_TRAP_EN.
module sequencer
    import sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter logic [63:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    output logic [63:0] iadr_o,
    output logic        icyc_o,
    output logic        istb_o,
    input  logic        iack_i,
    input  logic        ierr_i,
    input  logic [31:0] idat_i,
    output logic [2:0]  cstate_o,
    output logic [31:0] ir_o,
    input  logic [2:0]  nstate_i,
    input  logic        defined_i,
    output logic [63:0] pc_o,
    output logic        trap_o,
    output logic [3:0]  cause_o,
    output logic [63:0] epc_o
);

    state_t      state_reg,  state_next;
    logic [63:0] pc_reg,     pc_next;
    logic [31:0] ir_reg,     ir_next;
    logic [2:0]  cstate_reg, cstate_next;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg  <= ST_BOOT;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            cstate_reg <= CSTATE_IDLE;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            cstate_reg <= cstate_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        cstate_next = cstate_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // A bus error takes priority over a simultaneous ack.
                if (ierr_i) begin
`ifdef SEQUENCER_TRAP_EN
                    state_next = ST_TRAP;
`else
                    pc_next    = pc_reg + 64'd4;
                    state_next = ST_FETCH;
`endif
                end else if (iack_i) begin
                    ir_next     = idat_i;
                    cstate_next = 3'd0;
                    state_next  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cstate_reg == 3'd0 && !defined_i) begin
                    cstate_next = CSTATE_IDLE;
`ifdef SEQUENCER_TRAP_EN
                    state_next  = ST_TRAP;
`else
                    pc_next     = pc_reg + 64'd4;
                    state_next  = ST_FETCH;
`endif
                end else if (nstate_i >= CSTATE_DONE) begin
                    pc_next     = pc_reg + 64'd4;
                    cstate_next = CSTATE_IDLE;
                    state_next  = ST_FETCH;
                end else begin
                    cstate_next = nstate_i;
                end
            end
            ST_TRAP: begin
                pc_next    = TRAP_VEC;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign icyc_o   = (state_reg == ST_FETCH);
    assign istb_o   = (state_reg == ST_FETCH);
    assign iadr_o   = (state_reg == ST_FETCH) ? pc_reg : 64'd0;
    assign cstate_o = cstate_reg;
    assign ir_o     = ir_reg;
    assign pc_o     = pc_reg;

`ifdef SEQUENCER_TRAP_EN
    logic [3:0]  cause_reg;
    logic [63:0] epc_reg;

    // Cause is captured on the edge entering TRAP so it is valid with trap_o.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cause_reg <= '0;
            epc_reg   <= '0;
        end else begin
            if (state_reg == ST_FETCH && ierr_i) begin
                cause_reg <= CAUSE_IFAULT;
            end else if (state_reg == ST_EXEC && cstate_reg == 3'd0 && !defined_i) begin
                cause_reg <= CAUSE_ILLEGAL;
            end
            if (state_reg == ST_TRAP) begin
                epc_reg <= pc_reg;
            end
        end
    end

    assign trap_o  = (state_reg == ST_TRAP);
    assign cause_o = cause_reg;
    assign epc_o   = epc_reg;
`else
    assign trap_o  = 1'b0;
    assign cause_o = 4'd0;
    assign epc_o   = 64'd0;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer; plays the decode block and the
// instruction bus, with a queue of expected fetch addresses.
module tb_sequencer;

    localparam logic [63:0] RST_PC  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] TRP_VEC = 64'hFFFF_FFFF_FFFF_FE00;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [63:0] iadr_o;
    logic        icyc_o, istb_o;
    logic        iack_i, ierr_i;
    logic [31:0] idat_i;
    logic [2:0]  cstate_o;
    logic [31:0] ir_o;
    logic [2:0]  nstate_i;
    logic        defined_i;
    logic [63:0] pc_o;
    logic        trap_o;
    logic [3:0]  cause_o;
    logic [63:0] epc_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] idat;
        logic        err;
        int          waits;
        logic        exp_skip;
        logic [3:0]  exp_cause;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    sequencer dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .iadr_o   (iadr_o),
        .icyc_o   (icyc_o),
        .istb_o   (istb_o),
        .iack_i   (iack_i),
        .ierr_i   (ierr_i),
        .idat_i   (idat_i),
        .cstate_o (cstate_o),
        .ir_o     (ir_o),
        .nstate_i (nstate_i),
        .defined_i(defined_i),
        .pc_o     (pc_o),
        .trap_o   (trap_o),
        .cause_o  (cause_o),
        .epc_o    (epc_o)
    );

    // Minimal decode: all-ones is undefined, otherwise step 0->1->2->DONE.
    always_comb begin
        defined_i = (ir_o != 32'hFFFF_FFFF);
        nstate_i  = (cstate_o == 3'b111) ? 3'b111 : cstate_o + 3'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; completes one instruction and queues the next fetch address.
    task automatic run_instr(input logic [31:0] idat, input logic err, input int waits,
                             input logic exp_skip, input logic [3:0] exp_cause);
        logic [63:0] addr;
        logic [63:0] exp_addr;
        logic [31:0] ir_prev;
        bit          got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (istb_o) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got istb=0 expected istb=1");
            return;
        end
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("fetch_addr", iadr_o, exp_addr);
        addr    = exp_addr;
        ir_prev = ir_o;
        for (int w = 0; w < waits; w++) begin
            cyc();
            chk("wait_stb", {63'd0, istb_o}, 64'd1);
            chk("wait_adr", iadr_o, addr);
            chk("wait_ir", {32'd0, ir_o}, {32'd0, ir_prev});
        end
        idat_i = idat;
        iack_i = 1'b1;
        ierr_i = err;
        cyc();
        iack_i = 1'b0;
        ierr_i = 1'b0;
        chk("ir_latch", {32'd0, ir_o}, {32'd0, (err ? ir_prev : idat)});
        if (!exp_skip) begin
            chk("cstate0", {61'd0, cstate_o}, 64'd0);
            cyc();
            chk("cstate1", {61'd0, cstate_o}, 64'd1);
            cyc();
            chk("cstate2", {61'd0, cstate_o}, 64'd2);
            cyc();
            chk("refetch_stb", {63'd0, istb_o}, 64'd1);
            exp_q.push_back(addr + 64'd4);
        end else begin
            if (!err) begin
                chk("cstate0", {61'd0, cstate_o}, 64'd0);
                cyc();
            end
`ifdef SEQUENCER_TRAP_EN
            chk("trap_pulse", {63'd0, trap_o}, 64'd1);
            chk("cause", {60'd0, cause_o}, {60'd0, exp_cause});
            cyc();
            chk("trap_end", {63'd0, trap_o}, 64'd0);
            chk("cause_held", {60'd0, cause_o}, {60'd0, exp_cause});
            chk("epc", epc_o, addr);
            exp_q.push_back(TRP_VEC);
`else
            chk("no_trap", {63'd0, trap_o}, 64'd0);
            chk("cause_zero", {60'd0, cause_o}, {60'd0, 4'd0 & exp_cause});
            exp_q.push_back(addr + 64'd4);
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0050_0093, 1'b0, 0, 1'b0, 4'd0};
        vecs[1] = '{32'h00A0_0113, 1'b0, 3, 1'b0, 4'd0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 0, 1'b1, 4'd2};
        vecs[3] = '{32'h1234_5678, 1'b1, 1, 1'b1, 4'd1};
        vecs[4] = '{NOP,           1'b0, 2, 1'b0, 4'd0};

        // Reset with a stray ack held high through BOOT.
        reset_ni = 1'b0;
        iack_i   = 1'b1;
        ierr_i   = 1'b0;
        idat_i   = 32'hDEAD_BEEF;
        #12;
        chk("rst_stb", {63'd0, istb_o}, 64'd0);
        chk("rst_cyc", {63'd0, icyc_o}, 64'd0);
        chk("rst_cstate", {61'd0, cstate_o}, 64'd7);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_ir", {32'd0, ir_o}, 64'd0);
        chk("rst_trap", {63'd0, trap_o}, 64'd0);
        chk("rst_cause", {60'd0, cause_o}, 64'd0);
        chk("rst_epc", epc_o, 64'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        #1;
        chk("boot_stb", {63'd0, istb_o}, 64'd0);
        @(negedge clk);
        iack_i = 1'b0;
        chk("boot_ack_ignored", {32'd0, ir_o}, 64'd0);
        chk("first_stb", {63'd0, istb_o}, 64'd1);

        exp_q.push_back(RST_PC);
        for (int v = 0; v < 5; v++) begin
            run_instr(vecs[v].idat, vecs[v].err, vecs[v].waits, vecs[v].exp_skip, vecs[v].exp_cause);
        end

        // Walk PC up to the top of the address space and check the wrap to 0.
        for (int k = 0; k < 300 && exp_q.size() > 0 && exp_q[exp_q.size()-1] != 64'd0; k++) begin
            run_instr(NOP, 1'b0, 0, 1'b0, 4'd0);
        end
        run_instr(NOP, 1'b0, 0, 1'b0, 4'd0);

        // Reset during an outstanding fetch.
        chk("prefetch_stb", {63'd0, istb_o}, 64'd1);
        reset_ni = 1'b0;
        #1;
        chk("rst_fetch_stb", {63'd0, istb_o}, 64'd0);
        chk("rst_fetch_cyc", {63'd0, icyc_o}, 64'd0);
        chk("rst_fetch_pc", pc_o, RST_PC);
        @(negedge clk);
        reset_ni = 1'b1;
        cyc();
        chk("refetch_adr", iadr_o, RST_PC);
        idat_i = 32'h0050_0093;
        iack_i = 1'b1;
        cyc();
        iack_i = 1'b0;
        chk("re_cstate0", {61'd0, cstate_o}, 64'd0);
        cyc();
        chk("re_cstate1", {61'd0, cstate_o}, 64'd1);
        chk("re_pc", pc_o, RST_PC);

        // Reset in the middle of EXEC, between clock edges.
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst_exec_cstate", {61'd0, cstate_o}, 64'd7);
        chk("rst_exec_pc", pc_o, RST_PC);
        chk("rst_exec_ir", {32'd0, ir_o}, 64'd0);
        chk("rst_exec_stb", {63'd0, istb_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
